// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_unit
// Description : Sequential log-shifter (SRL/SLL/SRA/ROR) with one stage per cycle,
//               valid/ready handshake and SLL overflow detection.
//               Optional rotate datapath enabled by macro SEQ_SHIFT_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_done  = 2'd2;

    localparam logic [1:0] c_srl = 2'b00;
    localparam logic [1:0] c_sll = 2'b01;
    localparam logic [1:0] c_sra = 2'b10;
    localparam logic [1:0] c_ror = 2'b11;

    localparam logic [SHW-1:0] c_last = SHW'(SHW - 1);

    logic [1:0]       r_state;
    logic [SHW-1:0]   r_stage;
    logic [SHW-1:0]   r_amt;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [SHW:0]     w_sh;
    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_sra;
    logic             w_lost;
    logic [WIDTH-1:0] w_next;
    logic [1:0]       w_mode_in;
    logic             w_sat;

    // Stage k moves the working value by 2^k positions
    assign w_sh   = (SHW + 1)'(1) << r_stage;
    assign w_srl  = r_work >> w_sh;
    assign w_sll  = r_work << w_sh;
    assign w_sra  = $signed(r_work) >>> w_sh;
    assign w_lost = |(r_work & ~({WIDTH{1'b1}} >> w_sh));
    assign w_sat  = |b[WIDTH-1:SHW];

`ifdef SEQ_SHIFT_ROTATE_EN
    localparam logic [SHW:0] c_width = (SHW + 1)'(WIDTH);
    logic [WIDTH-1:0] w_ror;
    assign w_ror     = (r_work >> w_sh) | (r_work << (c_width - w_sh));
    assign w_mode_in = mode;
`else
    assign w_mode_in = (mode == c_ror) ? c_srl : mode;
`endif

    always_comb begin
        w_next = r_work;
        if (r_amt[0]) begin
            case (r_mode)
                c_sll:   w_next = w_sll;
                c_sra:   w_next = w_sra;
`ifdef SEQ_SHIFT_ROTATE_EN
                c_ror:   w_next = w_ror;
`endif
                default: w_next = w_srl;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_stage     <= '0;
            r_amt       <= '0;
            r_mode      <= c_srl;
            r_work      <= '0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_state    <= c_shift;
                        r_stage    <= '0;
                        r_mode     <= w_mode_in;
                        r_in_ready <= 1'b0;
                        // Saturated non-rotate shifts resolve at capture; the stages then idle
                        if (w_sat && (w_mode_in != c_ror)) begin
                            r_amt  <= '0;
                            r_work <= (w_mode_in == c_sra) ? {WIDTH{a[WIDTH-1]}} : '0;
                            r_ovf  <= (w_mode_in == c_sll) && (|a);
                        end else begin
                            r_amt  <= b[SHW-1:0];
                            r_work <= a;
                            r_ovf  <= 1'b0;
                        end
                    end
                end
                c_shift: begin
                    r_work <= w_next;
                    r_amt  <= r_amt >> 1;
                    if ((r_mode == c_sll) && r_amt[0] && w_lost) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_stage == c_last) begin
                        r_state     <= c_done;
                        r_out       <= w_next;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_stage <= r_stage + 1'b1;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state     <= c_idle;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_idle;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shift_unit
// Description : Directed self-checking bench for seq_shift_unit (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shift_unit;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    seq_shift_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for the result, check latency/value/overflow, then drain it.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_in,
                          input logic [1:0] tm, input logic [15:0] eo, input logic eov);
        int lat;
        lat = 0;
        @(negedge clk);
        check_val({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_in; mode = tm; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'd4);
        check_val({tag, "_out"}, 32'(out), 32'(eo));
        check_val({tag, "_ovf"}, 32'(overflow), 32'(eov));
        check_val({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_val({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] ror_exp;
    logic [15:0] held;
    int          seen;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 2'b00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out", 32'(out), 32'd0);
        check_val("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;

        // First capture lands on the first rising edge after reset release
        run_op("srl_f0f0_4",   16'hF0F0, 16'd4,     2'b00, 16'h0F0F, 1'b0);
        run_op("sll_8001_1",   16'h8001, 16'd1,     2'b01, 16'h0002, 1'b1);
        run_op("sll_0001_15",  16'h0001, 16'd15,    2'b01, 16'h8000, 1'b0);
        run_op("srl_sat",      16'hFFFF, 16'd16,    2'b00, 16'h0000, 1'b0);
        run_op("sra_sat",      16'h8000, 16'h0100,  2'b10, 16'hFFFF, 1'b0);
        run_op("sra_8000_3",   16'h8000, 16'd3,     2'b10, 16'hF000, 1'b0);
        run_op("sll_sat_ovf",  16'h0001, 16'd16,    2'b01, 16'h0000, 1'b1);
        run_op("sll_sat_zero", 16'h0000, 16'd20,    2'b01, 16'h0000, 1'b0);
        run_op("sra_amt0",     16'h1234, 16'd0,     2'b10, 16'h1234, 1'b0);
        run_op("sra_pos",      16'h7000, 16'd4,     2'b10, 16'h0700, 1'b0);
        run_op("sll_multi",    16'h0F00, 16'd5,     2'b01, 16'hE000, 1'b1);
        run_op("srl_8000_15",  16'h8000, 16'd15,    2'b00, 16'h0001, 1'b0);
        run_op("sra_ovf0",     16'h8001, 16'd1,     2'b10, 16'hC000, 1'b0);
`ifdef SEQ_SHIFT_ROTATE_EN
        ror_exp = 16'h8000;
`else
        ror_exp = 16'h0000;
`endif
        run_op("mode11_17",    16'h0001, 16'd17,    2'b11, ror_exp, 1'b0);

        // Backpressure: result must hold while out_ready stays low
        @(negedge clk);
        a = 16'hF0F0; b = 16'd4; mode = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1;
        seen = 0;
        while (!out_valid && seen < 20) begin
            @(posedge clk);
            #1 seen++;
        end
        check_val("bp_latency", 32'(seen), 32'd4);
        held = out;
        check_val("bp_value", 32'(held), 32'h0F0F);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("bp_out_stable_%0d", i), 32'(out), 32'(held));
            check_val($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
            check_val($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_val("bp_release", 32'(out_valid), 32'd0);
        check_val("bp_idle_ready", 32'(in_ready), 32'd1);

        // Reset mid-SHIFT discards the request
        @(negedge clk);
        a = 16'h8001; b = 16'd3; mode = 2'b01; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        check_val("midrst_out", 32'(out), 32'd0);
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);
        check_val("midrst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check_val("midrst_no_result", 32'(seen), 32'd0);

        run_op("after_rst",    16'h00FF, 16'd8,     2'b01, 16'hFF00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
